// File: rtl/ternary_pkg.sv
// Shared ternary encodings, mask levels and scan-sequencer state type.
package ternary_pkg;

  localparam int TRIT_W = 2;

  localparam logic [TRIT_W-1:0] TRIT_ZERO = 2'b00;
  localparam logic [TRIT_W-1:0] TRIT_ONE  = 2'b01;
  localparam logic [TRIT_W-1:0] TRIT_TWO  = 2'b10;
  localparam logic [TRIT_W-1:0] TRIT_BAD  = 2'b11;

  // Per-value mask levels; the MSB is the bit written into a position mask.
  localparam logic [1:0] HOT  = 2'b10;
  localparam logic [1:0] COLD = 2'b00;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_e;

endpackage

// File: rtl/trit_decode.sv
// Combinational single-trit classifier: exactly one of is0/is1/is2/bad is high.
module trit_decode
  import ternary_pkg::*;
(
  input  logic [TRIT_W-1:0] trit,
  output logic              is0,
  output logic              is1,
  output logic              is2,
  output logic              bad
);

  always_comb begin
    is0 = 1'b0;
    is1 = 1'b0;
    is2 = 1'b0;
    bad = 1'b0;
    case (trit)
      TRIT_ZERO: is0 = 1'b1;
      TRIT_ONE:  is1 = 1'b1;
      TRIT_TWO:  is2 = 1'b1;
      TRIT_BAD:  bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/trit_scan_ctrl.sv
// Captures an N-trit word and walks it one trit per clock through a shared
// decoder, accumulating counts and position masks into a held result record.
module trit_scan_ctrl
  import ternary_pkg::*;
#(
  parameter int N_TRITS = 8,
  parameter int CNT_W   = $clog2(N_TRITS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TRIT_W*N_TRITS-1:0]  in_word,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           cnt0,
  output logic [CNT_W-1:0]           cnt1,
  output logic [CNT_W-1:0]           cnt2,
  output logic [N_TRITS-1:0]         m0,
  output logic [N_TRITS-1:0]         m1,
  output logic [N_TRITS-1:0]         m2,
  output logic [N_TRITS-1:0]         bad_mask,
  output logic                       invalid,
  output logic                       busy
);

  localparam int IDX_W  = $clog2(N_TRITS);
  localparam int WORD_W = TRIT_W * N_TRITS;

  scan_state_e        state_q, state_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [N_TRITS-1:0] m0_q, m0_d, m1_q, m1_d, m2_q, m2_d, bad_q, bad_d;
  logic               clr;
  logic               dec_is0, dec_is1, dec_is2, dec_bad;

  trit_decode u_dec (
    .trit (shift_q[TRIT_W-1:0]),
    .is0  (dec_is0),
    .is1  (dec_is1),
    .is2  (dec_is2),
    .bad  (dec_bad)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    m0_d    = m0_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    bad_d   = bad_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        shift_d = in_word;
        idx_d   = '0;
        clr     = 1'b1;
        state_d = SCAN;
      end
      SCAN: begin
        if (dec_is0) cnt0_d = cnt0_q + CNT_W'(1);
        if (dec_is1) cnt1_d = cnt1_q + CNT_W'(1);
        if (dec_is2) cnt2_d = cnt2_q + CNT_W'(1);
        m0_d[idx_q]  = dec_is0 ? HOT[1] : COLD[1];
        m1_d[idx_q]  = dec_is1 ? HOT[1] : COLD[1];
        m2_d[idx_q]  = dec_is2 ? HOT[1] : COLD[1];
        bad_d[idx_q] = dec_bad;
        shift_d      = shift_q >> TRIT_W;
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N_TRITS - 1)) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush overrides acceptance and handshake alike; an accepted word is dropped.
    if (flush) begin
      state_d = IDLE;
      clr     = 1'b1;
    end
    if (clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
      cnt2_d = '0;
      m0_d   = '0;
      m1_d   = '0;
      m2_d   = '0;
      bad_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      m0_q    <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      m0_q    <= m0_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      bad_q   <= bad_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SCAN);
  assign out_valid = (state_q == DONE);
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;
  assign cnt2      = cnt2_q;
  assign m0        = m0_q;
  assign m1        = m1_q;
  assign m2        = m2_q;
  assign bad_mask  = bad_q;
  assign invalid   = |bad_q;

endmodule

// File: tb/tb_trit_scan_ctrl.sv
// Self-checking bench: a 4-trit and an 8-trit instance against a counting model.
module tb_trit_scan_ctrl;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, out_ready = 1'b0;
  logic        v4 = 1'b0, v8 = 1'b0;
  logic [15:0] w_in = '0;
  int          sel = 0;
  int          n_cmp = 0, n_bad = 0;

  logic       ir4, ov4, bz4, inv4;
  logic [2:0] c0_4, c1_4, c2_4;
  logic [3:0] m0_4, m1_4, m2_4, bm4;
  logic       ir8, ov8, bz8, inv8;
  logic [3:0] c0_8, c1_8, c2_8;
  logic [7:0] m0_8, m1_8, m2_8, bm8;

  trit_scan_ctrl #(.N_TRITS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .in_word(w_in[7:0]),
    .flush(flush), .out_valid(ov4), .out_ready(out_ready),
    .cnt0(c0_4), .cnt1(c1_4), .cnt2(c2_4), .m0(m0_4), .m1(m1_4), .m2(m2_4),
    .bad_mask(bm4), .invalid(inv4), .busy(bz4));

  trit_scan_ctrl #(.N_TRITS(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .in_word(w_in),
    .flush(flush), .out_valid(ov8), .out_ready(out_ready),
    .cnt0(c0_8), .cnt1(c1_8), .cnt2(c2_8), .m0(m0_8), .m1(m1_8), .m2(m2_8),
    .bad_mask(bm8), .invalid(inv8), .busy(bz8));

  always #5 clk = ~clk;

  // Views of whichever instance is selected.
  logic       ir, ov, bz, inv;
  logic [7:0] c0, c1, c2, m0, m1, m2, bm;
  always_comb begin
    ir = ir4; ov = ov4; bz = bz4; inv = inv4;
    c0 = {5'b0, c0_4}; c1 = {5'b0, c1_4}; c2 = {5'b0, c2_4};
    m0 = {4'b0, m0_4}; m1 = {4'b0, m1_4}; m2 = {4'b0, m2_4}; bm = {4'b0, bm4};
    if (sel != 0) begin
      ir = ir8; ov = ov8; bz = bz8; inv = inv8;
      c0 = {4'b0, c0_8}; c1 = {4'b0, c1_8}; c2 = {4'b0, c2_8};
      m0 = m0_8; m1 = m1_8; m2 = m2_8; bm = bm8;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (sel=%0d): got %0h expected %0h", tag, sel, got, exp);
    end
  endtask

  function automatic int ntr();
    return (sel != 0) ? 8 : 4;
  endfunction

  // Reference: tally each trit position from the word directly.
  task automatic model(input logic [15:0] w, output logic [7:0] e0, e1, e2,
                       output logic [7:0] em0, em1, em2, eb);
    int cnt[3];
    logic [7:0] msk[3];
    cnt = '{0, 0, 0};
    msk = '{8'h0, 8'h0, 8'h0};
    eb = 8'h0;
    for (int i = 0; i < ntr(); i++) begin
      int code;
      code = int'((w >> (2 * i)) & 16'h3);
      if (code == 3) eb[i] = 1'b1;
      else begin
        cnt[code]++;
        msk[code][i] = 1'b1;
      end
    end
    e0 = 8'(cnt[0]); e1 = 8'(cnt[1]); e2 = 8'(cnt[2]);
    em0 = msk[0]; em1 = msk[1]; em2 = msk[2];
  endtask

  task automatic check_res(input string tag, input logic [15:0] w);
    logic [7:0] e0, e1, e2, em0, em1, em2, eb;
    model(w, e0, e1, e2, em0, em1, em2, eb);
    chk({tag, ".cnt0"}, c0, e0);
    chk({tag, ".cnt1"}, c1, e1);
    chk({tag, ".cnt2"}, c2, e2);
    chk({tag, ".m0"}, m0, em0);
    chk({tag, ".m1"}, m1, em1);
    chk({tag, ".m2"}, m2, em2);
    chk({tag, ".bad_mask"}, bm, eb);
    chk({tag, ".invalid"}, inv, |eb);
    chk({tag, ".invariant"}, c0 + c1 + c2 + $countones(bm), ntr());
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, ".in_ready"}, ir, 1);
    chk({tag, ".busy"}, bz, 0);
    chk({tag, ".out_valid"}, ov, 0);
    chk({tag, ".counts"}, {c0, c1, c2}, 0);
    chk({tag, ".masks"}, {m0, m1, m2, bm}, 0);
    chk({tag, ".invalid"}, inv, 0);
  endtask

  task automatic accept(input string tag, input logic [15:0] w);
    int t = 0;
    while (!ir && t < 50) begin @(posedge clk); #1; t++; end
    chk({tag, ".in_ready_wait"}, ir, 1);
    w_in = w;
    if (sel != 0) v8 = 1'b1; else v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0; v8 = 1'b0;
    chk({tag, ".accept_busy"}, bz, 1);
  endtask

  // Expects out_valid to rise exactly N edges after the accepting edge.
  task automatic wait_done(input string tag);
    logic early = 1'b0;
    for (int k = 1; k <= ntr(); k++) begin
      @(posedge clk); #1;
      if (k < ntr() && ov) early = 1'b1;
    end
    chk({tag, ".early_valid"}, early, 0);
    chk({tag, ".latency_valid"}, ov, 1);
    chk({tag, ".done_in_ready"}, ir, 0);
  endtask

  task automatic run(input string tag, input logic [15:0] w, input int hold);
    out_ready = (hold == 0);
    accept(tag, w);
    wait_done(tag);
    check_res(tag, w);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, ov, 1);
      chk({tag, ".hold_in_ready"}, ir, 0);
      check_res({tag, ".hold"}, w);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".release_valid"}, ov, 0);
    chk({tag, ".release_in_ready"}, ir, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] w2;
    #1;
    sel = 0; chk_cleared("reset4");
    sel = 1; chk_cleared("reset8");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Scenario 1: mixed word, out_ready tied high.
    sel = 0;
    run("s1", 16'h0092, 0);

    // Scenario 2: illegal top trit.
    run("s2", 16'h00C0, 0);

    // Scenario 3: backpressure with a competing word offered.
    out_ready = 1'b0;
    accept("s3", 16'h0024);
    wait_done("s3");
    w2 = 16'h0019;
    w_in = w2;
    v4 = 1'b1;
    for (int h = 0; h < 6; h++) begin
      @(posedge clk); #1;
      chk("s3.hold_valid", ov, 1);
      chk("s3.hold_in_ready", ir, 0);
      chk("s3.hold_busy", bz, 0);
      check_res("s3.hold", 16'h0024);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("s3.handshake_valid", ov, 0);
    chk("s3.handshake_busy", bz, 0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    v4 = 1'b0;
    chk("s3.second_accept", bz, 1);
    wait_done("s3b");
    check_res("s3b", w2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Scenario 4: flush at idx=2.
    accept("s4", 16'h00E4);
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk_cleared("s4.flush");
    begin
      logic seen = 1'b0;
      repeat (8) begin @(posedge clk); #1; if (ov) seen = 1'b1; end
      chk("s4.no_valid", seen, 0);
    end
    run("s4b", 16'h0055, 0);

    // Scenario 5: asynchronous reset between edges.
    accept("s5", 16'h0092);
    repeat (2) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1 chk_cleared("s5.async");
    @(negedge clk); rst = 1'b0;
    begin
      logic seen = 1'b0;
      repeat (8) begin @(posedge clk); #1; if (ov) seen = 1'b1; end
      chk("s5.no_stale", seen, 0);
    end

    // Scenario 6: all-illegal 8-trit word.
    sel = 1;
    run("s6", 16'hFFFF, 0);

    // Randomized words on both instances with random backpressure.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 1));
      run("rnd", 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
